// File: rtl/request_scheduler.sv
// Traffic request scheduler: latches three requests and offers one phase at a time to the light
// sequencer. Optional macro PED_PRIORITY_EN lets a pending pedestrian request beat round-robin.
module request_scheduler #(
  parameter int unsigned MAX_WAIT = 200,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       la_rue_sensor,
  input  logic       orchard_sensor,
  input  logic       pedestrian_sensor,
  input  logic       grant_ready,
  input  logic       phase_done,
  output logic       grant_valid,
  output logic [1:0] grant_phase,
  output logic [2:0] pending,
  output logic [2:0] starve_alarm
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StOffer = 2'd1;
  localparam logic [1:0] StServe = 2'd2;

  localparam logic [1:0]       PhaseNone = 2'd3;
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       last_q, last_d;
  logic [2:0]       pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic [2:0] sensor_req;
  logic [2:0] accept_vec;
  logic [2:0] starved;
  logic [1:0] rr_first;
  logic [1:0] winner;
  logic       accept;

  // Returns the first requester set in req, scanning first, first+1, first+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] first);
    logic [1:0] c1, c2, c3;
    c1 = first;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    c3 = (c2 == 2'd2) ? 2'd0 : c2 + 2'd1;
    if (req[c1])      return c1;
    else if (req[c2]) return c2;
    else if (req[c3]) return c3;
    else              return PhaseNone;
  endfunction

  // Pedestrian button is active-low; normalise everything to active-high here.
  assign sensor_req = {~pedestrian_sensor, orchard_sensor, la_rue_sensor};
  assign accept     = (state_q == StOffer) && grant_ready;

  always_comb begin
    accept_vec = 3'b000;
    for (int i = 0; i < 3; i++) begin
      accept_vec[i] = accept && (phase_q == 2'(i));
      starve_alarm[i] = 32'(cnt_q[i]) >= MAX_WAIT;
    end
  end

  assign starved  = starve_alarm & pending_q;
  assign rr_first = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;

  always_comb begin
    winner = PhaseNone;
    if (starved[0])      winner = 2'd0;
    else if (starved[1]) winner = 2'd1;
    else if (starved[2]) winner = 2'd2;
`ifdef PED_PRIORITY_EN
    else if (pending_q[2]) winner = 2'd2;
`endif
    else winner = rr_pick(pending_q, rr_first);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        phase_d = PhaseNone;
        if (pending_q != 3'b000) begin
          state_d = StOffer;
          phase_d = winner;
        end
      end
      StOffer: begin
        if (grant_ready) state_d = StServe;
      end
      StServe: begin
        if (phase_done) begin
          state_d = StIdle;
          last_d  = phase_q;
          phase_d = PhaseNone;
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = PhaseNone;
      end
    endcase
  end

  // A set arriving in the accept cycle loses; the still-held sensor re-sets it next edge.
  assign pending_d = (pending_q | sensor_req) & ~accept_vec;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept_vec[i]) begin
        cnt_d[i] = '0;
      end else if (pending_q[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      phase_q   <= PhaseNone;
      last_q    <= 2'd2;
      pending_q <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign grant_valid = (state_q == StOffer);
  assign grant_phase = phase_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_request_scheduler.sv
// Scoreboard bench for request_scheduler: expected grant phases are queued by the stimulus and
// popped by a monitor on each accept. A second instance uses small MAX_WAIT/CNT_W for starvation.
module tb_request_scheduler;

  logic       clk;
  logic       reset_n;
  logic       la_rue_sensor, orchard_sensor, pedestrian_sensor;
  logic       grant_ready, phase_done;
  logic       grant_valid, s_grant_valid;
  logic [1:0] grant_phase, s_grant_phase;
  logic [2:0] pending, s_pending;
  logic [2:0] starve_alarm, s_starve_alarm;

  int         tests_run;
  int         tests_failed;
  logic [1:0] exp_q [$];
  logic [1:0] mon_exp;

  request_scheduler dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .la_rue_sensor     (la_rue_sensor),
    .orchard_sensor    (orchard_sensor),
    .pedestrian_sensor (pedestrian_sensor),
    .grant_ready       (grant_ready),
    .phase_done        (phase_done),
    .grant_valid       (grant_valid),
    .grant_phase       (grant_phase),
    .pending           (pending),
    .starve_alarm      (starve_alarm)
  );

  request_scheduler #(
    .MAX_WAIT (4),
    .CNT_W    (3)
  ) dut_s (
    .clk               (clk),
    .reset_n           (reset_n),
    .la_rue_sensor     (la_rue_sensor),
    .orchard_sensor    (orchard_sensor),
    .pedestrian_sensor (pedestrian_sensor),
    .grant_ready       (grant_ready),
    .phase_done        (phase_done),
    .grant_valid       (s_grant_valid),
    .grant_phase       (s_grant_phase),
    .pending           (s_pending),
    .starve_alarm      (s_starve_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the values seen here are what the next rising edge will accept.
  always @(negedge clk) begin
    if (reset_n && grant_valid && grant_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL accept_unexpected: got phase %0d, expected no accept", grant_phase);
      end else begin
        mon_exp = exp_q.pop_front();
        check("accept_phase", 32'(grant_phase), 32'(mon_exp));
      end
    end
  end

  task automatic run_grants(input int n);
    int waited;
    for (int g = 0; g < n; g++) begin
      waited = 0;
      while (!grant_valid && waited < 20) begin
        tick();
        waited++;
      end
      if (!grant_valid) begin
        tests_run++;
        tests_failed++;
        $display("FAIL grant_timeout: got no grant_valid in 20 cycles, expected an offer");
        return;
      end
      grant_ready = 1'b1;
      tick();
      grant_ready = 1'b0;
      phase_done  = 1'b1;
      tick();
      phase_done  = 1'b0;
    end
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    reset_n           = 1'b0;
    la_rue_sensor     = 1'b1;
    orchard_sensor    = 1'b1;
    pedestrian_sensor = 1'b0;
    grant_ready       = 1'b0;
    phase_done        = 1'b0;

    // Reset with all sensors asserted: nothing may be sampled.
    tick();
    tick();
    check("rst_valid", 32'(grant_valid), 0);
    check("rst_phase", 32'(grant_phase), 3);
    check("rst_pending", 32'(pending), 0);
    check("rst_alarm", 32'(starve_alarm), 0);

    // La Rue only after release: pending at edge 1, offer at edge 2.
    orchard_sensor    = 1'b0;
    pedestrian_sensor = 1'b1;
    reset_n           = 1'b1;
    tick();
    check("lr_pending_e1", 32'(pending), 32'b001);
    check("lr_valid_e1", 32'(grant_valid), 0);
    tick();
    check("lr_valid_e2", 32'(grant_valid), 1);
    check("lr_phase_e2", 32'(grant_phase), 0);
    la_rue_sensor = 1'b0;
    exp_q.push_back(2'd0);
    grant_ready = 1'b1;
    tick();
    check("lr_valid_serve", 32'(grant_valid), 0);
    check("lr_pending_clr", 32'(pending), 0);
    check("lr_phase_serve", 32'(grant_phase), 0);
    grant_ready = 1'b0;
    phase_done  = 1'b1;
    tick();
    phase_done  = 1'b0;
    check("lr_phase_idle", 32'(grant_phase), 3);

    // All three pending from reset (last_served = 2).
    reset_n = 1'b0;
    tick();
    reset_n           = 1'b1;
    la_rue_sensor     = 1'b1;
    orchard_sensor    = 1'b1;
    pedestrian_sensor = 1'b0;
    tick();
    la_rue_sensor     = 1'b0;
    orchard_sensor    = 1'b0;
    pedestrian_sensor = 1'b1;
    check("all_pending", 32'(pending), 32'b111);
`ifdef PED_PRIORITY_EN
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
`else
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
`endif
    run_grants(3);
    check("all_done_pending", 32'(pending), 0);

    // Stray grant_ready/phase_done in IDLE are ignored.
    grant_ready = 1'b1;
    phase_done  = 1'b1;
    tick();
    grant_ready = 1'b0;
    phase_done  = 1'b0;
    check("idle_ignore_valid", 32'(grant_valid), 0);
    check("idle_ignore_phase", 32'(grant_phase), 3);

    // Offer held for 10 cycles with sensor dropped; phase_done mid-offer is ignored.
    orchard_sensor = 1'b1;
    tick();
    orchard_sensor = 1'b0;
    tick();
    check("hold_offer_valid", 32'(grant_valid), 1);
    check("hold_offer_phase", 32'(grant_phase), 1);
    for (int i = 1; i <= 10; i++) begin
      phase_done = (i == 5);
      tick();
      check("hold_valid", 32'(grant_valid), 1);
      check("hold_phase", 32'(grant_phase), 1);
    end
    phase_done = 1'b0;
    exp_q.push_back(2'd1);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check("hold_accept", 32'(grant_valid), 0);
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;

    // Pedestrian held in its accept cycle: cleared on accept, re-set one edge later.
    pedestrian_sensor = 1'b0;
    tick();
    check("ped_pending", 32'(pending), 32'b100);
    tick();
    check("ped_offer", 32'(grant_phase), 2);
    exp_q.push_back(2'd2);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    check("ped_clr_on_accept", 32'(pending), 0);
    tick();
    check("ped_reset_next", 32'(pending), 32'b100);
    pedestrian_sensor = 1'b1;
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    exp_q.push_back(2'd2);
    run_grants(1);

    // Reset during SERVE, then a late phase_done must do nothing.
    la_rue_sensor = 1'b1;
    tick();
    la_rue_sensor = 1'b0;
    tick();
    check("srv_offer", 32'(grant_phase), 0);
    exp_q.push_back(2'd0);
    grant_ready    = 1'b1;
    orchard_sensor = 1'b1;
    tick();
    grant_ready    = 1'b0;
    orchard_sensor = 1'b0;
    check("srv_pending", 32'(pending), 32'b010);
    reset_n = 1'b0;
    tick();
    check("srv_rst_valid", 32'(grant_valid), 0);
    check("srv_rst_phase", 32'(grant_phase), 3);
    check("srv_rst_pending", 32'(pending), 0);
    check("srv_rst_alarm", 32'(starve_alarm), 0);
    reset_n    = 1'b1;
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    check("srv_late_done_valid", 32'(grant_valid), 0);
    check("srv_late_done_phase", 32'(grant_phase), 3);
    tick();
    check("srv_idle_valid", 32'(grant_valid), 0);

    // Starvation: orchard waits through a long SERVE in both instances.
    reset_n = 1'b0;
    tick();
    reset_n        = 1'b1;
    orchard_sensor = 1'b1;
    tick();
    orchard_sensor = 1'b0;
    tick();
    check("stv_offer1", 32'(grant_phase), 1);
    check("stv_s_offer1", 32'(s_grant_phase), 1);
    exp_q.push_back(2'd1);
    grant_ready = 1'b1;
    tick();
    grant_ready       = 1'b0;
    orchard_sensor    = 1'b1;
    pedestrian_sensor = 1'b0;
    tick();
    orchard_sensor    = 1'b0;
    pedestrian_sensor = 1'b1;
    check("stv_s_pending", 32'(s_pending), 32'b110);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("stv_s_alarm", 32'(s_starve_alarm), (k >= 4) ? 32'b110 : 32'b000);
      check("stv_alarm_dflt", 32'(starve_alarm), 0);
    end
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    check("stv_idle_phase", 32'(grant_phase), 3);
    tick();
    check("stv_rr_phase", 32'(grant_phase), 2);
    check("stv_s_valid", 32'(s_grant_valid), 1);
    check("stv_s_starved_phase", 32'(s_grant_phase), 1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    run_grants(2);

    tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/request_scheduler.md
REQUEST_SCHEDULER -- requirements
Module: request_scheduler

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 200: cycles a pending request waits before it is flagged starved.
REQ-002 SHALL have parameter CNT_W, default 8: width of each wait counter.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port la_rue_sensor  in  1  La Rue vehicle present, active-high.
REQ-006 SHALL have port orchard_sensor  in  1  Orchard vehicle present, active-high.
REQ-007 SHALL have port pedestrian_sensor  in  1  pedestrian button, active-low (0 = pedestrian present).
REQ-008 SHALL have port grant_ready  in  1  light sequencer accepts the offered phase.
REQ-009 SHALL have port phase_done  in  1  single-cycle pulse: granted phase has finished (including yellow/clearance).
REQ-010 SHALL have port grant_valid  out  1  phase offer valid.
REQ-011 SHALL have port grant_phase  out  2  0 = La Rue, 1 = Orchard, 2 = pedestrian, 3 = none.
REQ-012 SHALL have port pending  out  3  latched requests, bit0 La Rue, bit1 Orchard, bit2 pedestrian.
REQ-013 SHALL have port starve_alarm  out  3  per-requester wait counter >= MAX_WAIT.

Function
REQ-014 SHALL set pending[i] on the edge after its sensor is sampled asserted; pending[i] holds until accepted.
REQ-015 SHALL clear pending[i] on the accept edge (grant_valid & grant_ready with grant_phase = i); a set in that same cycle loses, re-set occurs next cycle if sensor still asserted.
REQ-016 SHALL implement FSM IDLE -> OFFER -> SERVE -> IDLE.
REQ-017 IDLE: when pending != 0, SHALL select a winner, load grant_phase, assert grant_valid and enter OFFER on the next edge; otherwise stay IDLE with grant_phase = 3.
REQ-018 OFFER: SHALL hold grant_valid = 1 and grant_phase stable until grant_ready = 1; accept edge moves to SERVE and deasserts grant_valid.
REQ-019 SERVE: SHALL wait for phase_done, then record the served phase as last_served and return to IDLE; grant_phase stays at the served value during SERVE, 3 in IDLE.
REQ-020 Winner selection SHALL be: lowest-index starved requester first; else round-robin starting at (last_served + 1) mod 3.
REQ-021 Latency: sensor asserted in cycle N with FSM IDLE and no other pending -> pending set at N+1, grant_valid at N+2.
REQ-022 Each wait counter SHALL increment every cycle its pending bit is 1 and not accepted, clear on accept, saturate at 2^CNT_W - 1 (no wrap).
REQ-023 starve_alarm[i] SHALL be combinational compare counter[i] >= MAX_WAIT.
REQ-024 phase_done outside SERVE and grant_ready outside OFFER SHALL be ignored.
REQ-025 Sensor deassertion after pending is set SHALL NOT withdraw the request or an outstanding offer.

Reset
REQ-026 On any rising edge with reset_n = 0, including mid-OFFER or mid-SERVE: state = IDLE, pending = 0, all counters = 0, grant_valid = 0, grant_phase = 3, starve_alarm = 0, last_served = 2 (La Rue served first).
REQ-027 Sensors SHALL NOT be sampled during reset; first sampling on the first edge with reset_n = 1.

Configuration
REQ-028 Macro PED_PRIORITY_EN: when defined, a pending pedestrian request SHALL win over round-robin (starvation override still ranks above it); when undefined, pedestrian takes a normal round-robin slot.

Verification
REQ-029 Reset, then la_rue_sensor = 1 only, grant_ready = 1 -> grant_valid at 2nd edge after reset release, grant_phase = 0, pending[0] cleared on accept.
REQ-030 All three requests simultaneously pending from IDLE, last_served = 2, macro undefined -> grants in order 0, 1, 2; with PED_PRIORITY_EN -> 2, 0, 1.
REQ-031 Offer pending, grant_ready held 0 for 10 cycles, sensor deasserted -> grant_valid/grant_phase stable all 10 cycles, accept on 11th.
REQ-032 MAX_WAIT = 4, CNT_W = 3, orchard pending through a long SERVE -> starve_alarm[1] = 1 after 4 cycles, counter saturates at 7, orchard wins next IDLE regardless of round-robin.
REQ-033 reset_n = 0 for one edge during SERVE -> all outputs at reset values next cycle, later phase_done pulse ignored.
REQ-034 pedestrian_sensor = 0 in accept cycle of pedestrian grant -> pending[2] = 0 after accept, re-set one edge later.
